// File: rtl/refill_word_sequencer_if.sv
// Bus bundle for the refill word sequencer: the block-accept handshake from
// memory and the fill-stream handshake toward the cache data-array writer.
//
// Handshake rule used on both channels: a transfer happens on a rising clock
// edge where valid and ready are both high; once valid is raised, the sender
// holds its payload and keeps valid high until that transfer.
interface refill_word_sequencer_if #(
    parameter int WORD_WIDTH      = 20,
    parameter int WORDS_PER_BLOCK = 16
);
    localparam int B_OFFSET_BITS  = $clog2(WORDS_PER_BLOCK);
    localparam int MEM_DATA_WIDTH = WORD_WIDTH * WORDS_PER_BLOCK;

    // block-accept channel
    logic [MEM_DATA_WIDTH-1:0] i_mem_data;
    logic [B_OFFSET_BITS-1:0]  i_block_offset_bits;
    logic                      i_valid;
    logic                      o_ready;

    // missed-word side band to fetch
    logic [WORD_WIDTH-1:0]     o_missed_word;
    logic                      o_missed_valid;

    // fill stream channel
    logic [WORD_WIDTH-1:0]     o_fill_word;
    logic [B_OFFSET_BITS-1:0]  o_fill_idx;
    logic                      o_fill_valid;
    logic                      i_fill_ready;
    logic                      o_fill_done;

    // status / debug
    logic                      o_busy;
    logic                      o_state_dbg;   // 0 = IDLE, 1 = STREAM

    // driven by the memory side and the data-array writer
    modport master (
        output i_mem_data, i_block_offset_bits, i_valid, i_fill_ready,
        input  o_ready, o_missed_word, o_missed_valid, o_fill_word,
               o_fill_idx, o_fill_valid, o_fill_done, o_busy, o_state_dbg
    );

    // the sequencer itself
    modport slave (
        input  i_mem_data, i_block_offset_bits, i_valid, i_fill_ready,
        output o_ready, o_missed_word, o_missed_valid, o_fill_word,
               o_fill_idx, o_fill_valid, o_fill_done, o_busy, o_state_dbg
    );
endinterface

// File: rtl/refill_word_sequencer.sv
// Refill word sequencer: latches one memory block per accept, presents the
// missed word to fetch one cycle later, then streams every word of the block
// (with its index) to the cache data-array writer, either critical-word-first
// with wrap-around or linearly from word 0.
module refill_word_sequencer #(
    parameter int WORD_WIDTH      = 20,
    parameter int WORDS_PER_BLOCK = 16,
    parameter bit WRAP_MODE       = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    refill_word_sequencer_if.slave   bus
);
    localparam int B_OFFSET_BITS  = $clog2(WORDS_PER_BLOCK);
    localparam int MEM_DATA_WIDTH = WORD_WIDTH * WORDS_PER_BLOCK;
    localparam logic [B_OFFSET_BITS-1:0] LAST_BEAT = B_OFFSET_BITS'(WORDS_PER_BLOCK - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                    state_q;
    logic [MEM_DATA_WIDTH-1:0] block_q;
    logic [B_OFFSET_BITS-1:0]  start_q;
    logic [B_OFFSET_BITS-1:0]  count_q;

    logic [WORD_WIDTH-1:0]     missed_word_q;
    logic                      missed_valid_q;
    logic [WORD_WIDTH-1:0]     fill_word_q;
    logic [B_OFFSET_BITS-1:0]  fill_idx_q;
    logic                      fill_valid_q;
    logic                      fill_done_q;
    logic                      busy_q;

    logic [B_OFFSET_BITS-1:0]  start_d;
    logic [B_OFFSET_BITS-1:0]  next_idx_d;
    logic                      accept;

    function automatic logic [WORD_WIDTH-1:0] word_at(
        input logic [MEM_DATA_WIDTH-1:0] blk,
        input logic [B_OFFSET_BITS-1:0]  k
    );
        return blk[int'(k)*WORD_WIDTH +: WORD_WIDTH];
    endfunction

    // Ready only in IDLE and never while reset is asserted.
    assign bus.o_ready = (state_q == IDLE) && !i_reset;
    assign accept      = bus.i_valid && bus.o_ready;

    // Stream start index and the index of the beat after the current one;
    // the add wraps naturally in B_OFFSET_BITS.
    always_comb begin
        start_d    = '0;
        next_idx_d = '0;
        if (WRAP_MODE) start_d = bus.i_block_offset_bits;
        next_idx_d = start_q + count_q + B_OFFSET_BITS'(1);
    end

    // Single FSM: block capture, beat sequencing and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q        <= IDLE;
            block_q        <= '0;
            start_q        <= '0;
            count_q        <= '0;
            missed_word_q  <= '0;
            missed_valid_q <= 1'b0;
            fill_word_q    <= '0;
            fill_idx_q     <= '0;
            fill_valid_q   <= 1'b0;
            fill_done_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            // pulses default low; set below only on their event
            missed_valid_q <= 1'b0;
            fill_done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q        <= STREAM;
                        block_q        <= bus.i_mem_data;
                        start_q        <= start_d;
                        count_q        <= '0;
                        busy_q         <= 1'b1;
                        // first beat and missed word come straight from the
                        // incoming block so both appear one cycle after accept
                        missed_word_q  <= word_at(bus.i_mem_data, bus.i_block_offset_bits);
                        missed_valid_q <= 1'b1;
                        fill_valid_q   <= 1'b1;
                        fill_idx_q     <= start_d;
                        fill_word_q    <= word_at(bus.i_mem_data, start_d);
                    end
                end
                STREAM: begin
                    // fill_valid is always high here, so ready alone moves a beat
                    if (bus.i_fill_ready) begin
                        if (count_q == LAST_BEAT) begin
                            state_q      <= IDLE;
                            fill_valid_q <= 1'b0;
                            fill_done_q  <= 1'b1;
                            busy_q       <= 1'b0;
                            count_q      <= '0;
                        end else begin
                            count_q     <= count_q + B_OFFSET_BITS'(1);
                            fill_idx_q  <= next_idx_d;
                            fill_word_q <= word_at(block_q, next_idx_d);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_missed_word  = missed_word_q;
    assign bus.o_missed_valid = missed_valid_q;
    assign bus.o_fill_word    = fill_word_q;
    assign bus.o_fill_idx     = fill_idx_q;
    assign bus.o_fill_valid   = fill_valid_q;
    assign bus.o_fill_done    = fill_done_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_state_dbg    = state_q;
endmodule

// File: tb/tb_refill_word_sequencer.sv
// Directed bench for refill_word_sequencer: one wrap-mode instance and one
// linear-mode instance sharing clock, reset and payload inputs.
module tb_refill_word_sequencer;
    localparam int WW  = 20;
    localparam int N   = 16;
    localparam int OB  = 4;
    localparam int MDW = WW * N;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [MDW-1:0] mem_data = '0;
    logic [OB-1:0]  offset = '0;
    logic           valid = 1'b0;
    logic           fill_ready = 1'b0;
    logic           sel_lin = 1'b0;

    int total = 0;
    int bad   = 0;
    bit first_beat;

    always #5 clk = ~clk;

    refill_word_sequencer_if #(.WORD_WIDTH(WW), .WORDS_PER_BLOCK(N)) if_w ();
    refill_word_sequencer_if #(.WORD_WIDTH(WW), .WORDS_PER_BLOCK(N)) if_l ();

    assign if_w.i_mem_data          = mem_data;
    assign if_w.i_block_offset_bits = offset;
    assign if_w.i_valid             = valid & ~sel_lin;
    assign if_w.i_fill_ready        = fill_ready;
    assign if_l.i_mem_data          = mem_data;
    assign if_l.i_block_offset_bits = offset;
    assign if_l.i_valid             = valid & sel_lin;
    assign if_l.i_fill_ready        = fill_ready;

    refill_word_sequencer #(.WORD_WIDTH(WW), .WORDS_PER_BLOCK(N), .WRAP_MODE(1'b1)) dut_w (
        .i_clk(clk), .i_reset(rst), .bus(if_w)
    );
    refill_word_sequencer #(.WORD_WIDTH(WW), .WORDS_PER_BLOCK(N), .WRAP_MODE(1'b0)) dut_l (
        .i_clk(clk), .i_reset(rst), .bus(if_l)
    );

    // observed outputs of whichever instance is under test
    logic [WW-1:0] o_mw, o_fw;
    logic [OB-1:0] o_fi;
    logic o_rdy, o_mv, o_fv, o_fd, o_busy, o_st;
    assign o_mw   = sel_lin ? if_l.o_missed_word  : if_w.o_missed_word;
    assign o_fw   = sel_lin ? if_l.o_fill_word    : if_w.o_fill_word;
    assign o_fi   = sel_lin ? if_l.o_fill_idx     : if_w.o_fill_idx;
    assign o_rdy  = sel_lin ? if_l.o_ready        : if_w.o_ready;
    assign o_mv   = sel_lin ? if_l.o_missed_valid : if_w.o_missed_valid;
    assign o_fv   = sel_lin ? if_l.o_fill_valid   : if_w.o_fill_valid;
    assign o_fd   = sel_lin ? if_l.o_fill_done    : if_w.o_fill_done;
    assign o_busy = sel_lin ? if_l.o_busy         : if_w.o_busy;
    assign o_st   = sel_lin ? if_l.o_state_dbg    : if_w.o_state_dbg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MDW-1:0] make_block(input logic [WW-1:0] base);
        logic [MDW-1:0] b;
        b = '0;
        for (int k = 0; k < N; k++) b[k*WW +: WW] = base + WW'(k);
        return b;
    endfunction

    // Present a block, clock the accept edge, land in the first beat cycle.
    task automatic accept_block(input logic [WW-1:0] base, input int off);
        mem_data = make_block(base);
        offset   = OB'(off);
        valid    = 1'b1;
        tick();
        valid    = 1'b0;
        check("accept_missed_valid", 32'(o_mv), 32'd1);
        check("accept_missed_word", 32'(o_mw), 32'(base) + 32'(off));
        first_beat = 1'b1;
    endtask

    task automatic check_beat(input logic [WW-1:0] base, input int off, input int idx);
        check("beat_valid", 32'(o_fv), 32'd1);
        check("beat_idx", 32'(o_fi), 32'(idx));
        check("beat_word", 32'(o_fw), 32'(base) + 32'(idx));
        check("beat_missed_valid", 32'(o_mv), first_beat ? 32'd1 : 32'd0);
        check("beat_missed_hold", 32'(o_mw), 32'(base) + 32'(off));
        check("beat_done_low", 32'(o_fd), 32'd0);
        check("beat_busy", 32'(o_busy), 32'd1);
        check("beat_not_ready", 32'(o_rdy), 32'd0);
        check("beat_state", 32'(o_st), 32'd1);
        first_beat = 1'b0;
    endtask

    // Walk all N beats from the first-beat cycle and end on the done cycle.
    task automatic stream_block(input logic [WW-1:0] base, input int off,
                                input bit wrap, input bit toggle);
        int idx;
        for (int b = 0; b < N; b++) begin
            idx = wrap ? (off + b) % N : b;
            if (toggle && b > 0) begin
                fill_ready = 1'b0;
                check_beat(base, off, idx);
                tick();
                check_beat(base, off, idx);
            end
            fill_ready = 1'b1;
            check_beat(base, off, idx);
            tick();
        end
        check("done_pulse", 32'(o_fd), 32'd1);
        check("done_valid_low", 32'(o_fv), 32'd0);
        check("done_busy_low", 32'(o_busy), 32'd0);
        check("done_ready", 32'(o_rdy), 32'd1);
        check("done_state", 32'(o_st), 32'd0);
    endtask

    initial begin
        // reset held for two edges
        tick();
        tick();
        check("rst_ready_low", 32'(o_rdy), 32'd0);
        check("rst_missed_word", 32'(o_mw), 32'd0);
        check("rst_missed_valid", 32'(o_mv), 32'd0);
        check("rst_fill_word", 32'(o_fw), 32'd0);
        check("rst_fill_idx", 32'(o_fi), 32'd0);
        check("rst_fill_valid", 32'(o_fv), 32'd0);
        check("rst_done", 32'(o_fd), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(o_rdy), 32'd1);

        // wrap mode, offset 5, ready held high: done at T+17
        fill_ready = 1'b1;
        accept_block(20'hA0000, 5);
        stream_block(20'hA0000, 5, 1'b1, 1'b0);
        tick();
        check("done_one_cycle", 32'(o_fd), 32'd0);

        // offset 15: wraps right after the first beat
        accept_block(20'hA0000, 15);
        stream_block(20'hA0000, 15, 1'b1, 1'b0);
        tick();

        // offset 3 with ready toggling 1,0,1,0
        accept_block(20'hA0000, 3);
        stream_block(20'hA0000, 3, 1'b1, 1'b1);
        tick();
        check("toggle_done_once", 32'(o_fd), 32'd0);

        // second block held valid during streaming, accepted on done cycle
        accept_block(20'hA0000, 2);
        mem_data = make_block(20'hB0000);
        offset   = OB'(6);
        valid    = 1'b1;
        stream_block(20'hA0000, 2, 1'b1, 1'b0);
        tick();
        valid = 1'b0;
        check("held_missed_valid", 32'(o_mv), 32'd1);
        check("held_missed_word", 32'(o_mw), 32'hB0006);
        first_beat = 1'b1;
        stream_block(20'hB0000, 6, 1'b1, 1'b0);
        tick();

        // reset pulsed while beat 7 is on the bus
        accept_block(20'hA0000, 0);
        for (int b = 0; b < 7; b++) tick();
        check("pre_rst_idx", 32'(o_fi), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_missed_word", 32'(o_mw), 32'd0);
        check("abort_missed_valid", 32'(o_mv), 32'd0);
        check("abort_fill_word", 32'(o_fw), 32'd0);
        check("abort_fill_idx", 32'(o_fi), 32'd0);
        check("abort_fill_valid", 32'(o_fv), 32'd0);
        check("abort_done", 32'(o_fd), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_ready", 32'(o_rdy), 32'd1);
        tick();
        check("abort_no_done", 32'(o_fd), 32'd0);
        check("abort_no_beat", 32'(o_fv), 32'd0);
        accept_block(20'hA0000, 12);
        stream_block(20'hA0000, 12, 1'b1, 1'b0);
        tick();

        // linear mode, offset 9
        sel_lin = 1'b1;
        #1;
        check("lin_idle_ready", 32'(o_rdy), 32'd1);
        check("lin_idle_valid", 32'(o_fv), 32'd0);
        accept_block(20'hA0000, 9);
        stream_block(20'hA0000, 9, 1'b0, 1'b0);
        tick();
        check("lin_done_once", 32'(o_fd), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
